// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared definitions for the 4-way round-robin arbiter:
//                FSM state encoding, requester count / index width, and the
//                rotating-priority winner pick.
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set request bit when scanning ptr, ptr+1, ... (mod N_REQ).
    // The index arithmetic wraps naturally in IDX_W bits. Returns ptr when
    // no request is set; callers qualify the result with |req.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] w_idx;
        logic [IDX_W-1:0] w_cand;
        logic             w_found;
        w_idx   = ptr;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = ptr + IDX_W'(k);
            if (!w_found && req[w_cand]) begin
                w_idx   = w_cand;
                w_found = 1'b1;
            end
        end
        return w_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder2_4.sv
`default_nettype none
// ============================================================================
//  Module      : decoder2_4
//  Description : 2-to-4 line decoder. a is the MSB, b the LSB; exactly one
//                of d0..d3 is high for every input combination.
//  Ports       : a, b   in  select bits (a = MSB)
//                d0..d3 out decoded lines
//  Revision    : 1.0  initial release
// ============================================================================
module decoder2_4 (
    input  logic a,
    input  logic b,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3
);

    assign d0 = ~a & ~b;
    assign d1 = ~a &  b;
    assign d2 =  a & ~b;
    assign d3 =  a &  b;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter4
//  Description : Round-robin arbiter, four requesters, one shared resource.
//                A winner is picked from IDLE with rotating priority, held
//                until it drops its request or the hold timer expires, and
//                decoded to a one-hot grant. One dead IDLE cycle separates
//                consecutive grants.
//  Ports       : clk        in   rising-edge clock
//                rst_n      in   synchronous reset, active-low
//                req[3:0]   in   request per requester
//                gnt[3:0]   out  one-hot grant, 0000 when idle
//                gnt_valid  out  a grant is active
//                gnt_idx    out  encoded owner index (valid with gnt_valid)
//                timeout    out  one-cycle pulse on forced revocation
//  Params      : MAX_HOLD   max consecutive grant cycles, 0 = unlimited
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    localparam bit c_TIMER_EN = (MAX_HOLD > 0);
    // Counter must hold 0..MAX_HOLD-1; keep at least one bit when unlimited.
    localparam int c_CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [c_CNT_W-1:0] r_hold_cnt;
    logic               r_timeout;

    logic [IDX_W-1:0]   w_winner;
    logic               w_owner_req;
    logic               w_hold_last;
    logic               w_d0;
    logic               w_d1;
    logic               w_d2;
    logic               w_d3;

    assign w_winner    = rr_pick(req, r_ptr);
    assign w_owner_req = req[r_gnt_idx];

    generate
        if (c_TIMER_EN) begin : g_timer
            assign w_hold_last = (r_hold_cnt == c_CNT_W'(MAX_HOLD - 1));
        end else begin : g_no_timer
            assign w_hold_last = 1'b0;
        end
    endgenerate

    // Release is checked before the timer so a coincident drop of the
    // request is a plain release with no timeout pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt_idx  <= '0;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state    <= GRANT;
                        r_gnt_idx  <= w_winner;
                        r_hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!w_owner_req) begin
                        r_state <= IDLE;
                        r_ptr   <= r_gnt_idx + IDX_W'(1);
                    end else if (w_hold_last) begin
                        r_state   <= IDLE;
                        r_ptr     <= r_gnt_idx + IDX_W'(1);
                        r_timeout <= 1'b1;
                    end else if (c_TIMER_EN) begin
                        r_hold_cnt <= r_hold_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    decoder2_4 u_dec (
        .a  (r_gnt_idx[1]),
        .b  (r_gnt_idx[0]),
        .d0 (w_d0),
        .d1 (w_d1),
        .d2 (w_d2),
        .d3 (w_d3)
    );

    assign gnt_valid = (r_state == GRANT);
    assign gnt       = {w_d3, w_d2, w_d1, w_d0} & {N_REQ{gnt_valid}};
    assign gnt_idx   = r_gnt_idx;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter4
//  Description : Self-checking bench for rr_arbiter4 (MAX_HOLD = 8).
//                Directed vector table followed by random requests checked
//                against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       timeout;

    int total;
    int bad;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input logic t);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.gnt   = g;
        v.to    = t;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check_outputs(input string tag, input int step, input logic [3:0] eg, input logic et);
        chk({tag, "_gnt"},     step, gnt,                eg);
        chk({tag, "_valid"},   step, {3'b0, gnt_valid},  {3'b0, |eg});
        chk({tag, "_timeout"}, step, {3'b0, timeout},    {3'b0, et});
        if (eg != 4'b0000)
            chk({tag, "_idx"}, step, {2'b0, gnt_idx}, {2'b0, onehot_idx(eg)});
    endtask

    // Reference model: owner (-1 = idle), rotating start position, and the
    // number of grant cycles the current owner has already received.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    task automatic model_step(input logic r, input logic [3:0] q);
        if (!r) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && q[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_held  = 1;
                end
            end
        end else if (!q[m_owner]) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_to = 0;
        end else if (m_held == MAX_HOLD) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_to = 1;
        end else begin
            m_held++; m_to = 0;
        end
    endtask

    initial begin
        logic [3:0] eg;
        total = 0;
        bad   = 0;

        // 1. reset with all requests asserted
        for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0000, 0);
        // 2. single request from idle, then release (ptr -> 3)
        add(1, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 4'b0000, 0);
        // ptr=3 picks requester 3 ahead of 0
        add(1, 4'b1001, 4'b1000, 0);
        // 5. owner 3 releases, ptr wraps to 0
        add(1, 4'b0001, 4'b0000, 0);
        add(1, 4'b1001, 4'b0001, 0);
        add(1, 4'b0000, 4'b0000, 0);
        // 3. fresh reset, then all request, each owner holds 2 cycles
        add(0, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 4'b0001, 0);
        add(1, 4'b1111, 4'b0001, 0);
        add(1, 4'b1110, 4'b0000, 0);
        add(1, 4'b1111, 4'b0010, 0);
        add(1, 4'b1111, 4'b0010, 0);
        add(1, 4'b1101, 4'b0000, 0);
        add(1, 4'b1111, 4'b0100, 0);
        add(1, 4'b1111, 4'b0100, 0);
        add(1, 4'b1011, 4'b0000, 0);
        add(1, 4'b1111, 4'b1000, 0);
        add(1, 4'b1111, 4'b1000, 0);
        add(1, 4'b0111, 4'b0000, 0);
        add(1, 4'b1111, 4'b0001, 0);
        add(1, 4'b0000, 4'b0000, 0);
        // 4. requester 1 holds forever: 8 grant cycles, timeout, regrant
        for (int i = 0; i < 8; i++) add(1, 4'b0010, 4'b0010, 0);
        add(1, 4'b0010, 4'b0000, 1);
        add(1, 4'b0010, 4'b0010, 0);
        add(1, 4'b0000, 4'b0000, 0);
        // release coinciding with the last allowed cycle: no timeout pulse
        for (int i = 0; i < 8; i++) add(1, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 0);
        // 6. reset mid-grant, then first grant after reset goes to 0
        add(1, 4'b1000, 4'b1000, 0);
        add(1, 4'b1000, 4'b1000, 0);
        add(0, 4'b1000, 4'b0000, 0);
        add(1, 4'b1111, 4'b0001, 0);

        rst_n = 1'b0;
        req   = 4'b1111;
        // Directed table
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            @(posedge clk);
            #1;
            check_outputs("vec", i, vecs[i].gnt, vecs[i].to);
        end

        // Random phase against the reference model
        rst_n = 1'b0;
        req   = 4'b0000;
        model_step(rst_n, req);
        @(posedge clk);
        #1;
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            model_step(rst_n, req);
            @(posedge clk);
            #1;
            eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            check_outputs("rnd", c, eg, m_to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
